br_ecc_sed_error_logger: RTL and testbench

- Sits directly downstream of the SED (even-parity) decoder and consumes its output beat stream: valid, codeword and detected-uncorrectable-error flag.
- Counts detected errors and captures the first erroneous codeword plus its beat index since the last clear.
- Raises a level interrupt and flags overflow when more errors arrive before software clears the log.
- Purely observational: it applies no backpressure and does not modify the data path.

---
 rtl/br_ecc_sed_error_logger_pkg.sv | 14 +
 rtl/br_ecc_sat_counter.sv | 38 +++
 rtl/br_ecc_sed_error_logger.sv | 101 ++++++++++
 tb/tb_br_ecc_sed_error_logger.sv | 125 ++++++++++++
 4 files changed

// File: rtl/br_ecc_sed_error_logger_pkg.sv
// Shared types and helpers for the SED error logger.
package br_ecc_sed_error_logger_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOGGED   = 2'd1,
        OVERFLOW = 2'd2
    } state_e;

    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/br_ecc_sat_counter.sv
// Saturating up-counter; an increment coinciding with a clear yields 1.
module br_ecc_sat_counter
    import br_ecc_sed_error_logger_pkg::*;
#(
    parameter int Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             incr,
    input  logic             clr,
    output logic [Width-1:0] value
);

    localparam logic [Width-1:0] MaxVal = Width'(sat_max(Width));

    logic [Width-1:0] value_q;
    logic [Width-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = incr ? Width'(1) : '0;
        end else if (incr && (value_q != MaxVal)) begin
            value_d = value_q + Width'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/br_ecc_sed_error_logger.sv
// Observes the SED decoder beat stream and logs first error, error count and overflow.
module br_ecc_sed_error_logger
    import br_ecc_sed_error_logger_pkg::*;
#(
    parameter int DataWidth  = 1,
    parameter int CountWidth = 8,
    parameter int IndexWidth = 16,
    localparam int CodewordWidth = DataWidth + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dec_valid,
    input  logic [CodewordWidth-1:0] dec_codeword,
    input  logic                     dec_error_due,
    input  logic                     clear,
    output logic                     err_irq,
    output logic                     err_overflow,
    output logic [CountWidth-1:0]    err_count,
    output logic [CodewordWidth-1:0] first_err_codeword,
    output logic [IndexWidth-1:0]    first_err_index
);

    if (DataWidth < 1) begin : g_bad_data_width
        $error("DataWidth must be >= 1");
    end
    if (CountWidth < 1) begin : g_bad_count_width
        $error("CountWidth must be >= 1");
    end
    if (IndexWidth < 1) begin : g_bad_index_width
        $error("IndexWidth must be >= 1");
    end

    state_e                   state_q;
    logic [IndexWidth-1:0]    idx_q;
    logic [IndexWidth-1:0]    idx_d;
    logic [CodewordWidth-1:0] cw_q;
    logic [IndexWidth-1:0]    cap_idx_q;
    logic                     err_beat;

    assign err_beat = dec_valid && dec_error_due;

    // A clear restarts numbering at the current beat, so a coincident valid beat is index 0.
    always_comb begin
        idx_d = idx_q;
        if (clear) begin
            idx_d = dec_valid ? IndexWidth'(1) : '0;
        end else if (dec_valid) begin
            idx_d = idx_q + IndexWidth'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cw_q      <= '0;
            cap_idx_q <= '0;
        end else begin
            idx_q <= idx_d;
            if (clear) begin
                state_q   <= err_beat ? LOGGED : IDLE;
                cw_q      <= err_beat ? dec_codeword : '0;
                cap_idx_q <= '0;
            end else if (err_beat) begin
                case (state_q)
                    IDLE: begin
                        state_q   <= LOGGED;
                        cw_q      <= dec_codeword;
                        cap_idx_q <= idx_q;
                    end
                    default: state_q <= OVERFLOW;
                endcase
            end
        end
    end

    br_ecc_sat_counter #(
        .Width (CountWidth)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .incr  (err_beat),
        .clr   (clear),
        .value (err_count)
    );

    assign err_irq            = (state_q != IDLE);
    assign err_overflow       = (state_q == OVERFLOW);
    assign first_err_codeword = cw_q;
    assign first_err_index    = cap_idx_q;

    a_ovf_implies_irq : assert property (@(posedge clk) disable iff (!rst_n)
        err_overflow |-> err_irq);
    a_irq_implies_count : assert property (@(posedge clk) disable iff (!rst_n)
        err_irq |-> (err_count != '0));
    c_saturated : cover property (@(posedge clk) disable iff (!rst_n)
        err_count == CountWidth'(sat_max(CountWidth)));
    c_clear_with_error : cover property (@(posedge clk) disable iff (!rst_n)
        clear && err_beat);

endmodule

// File: tb/tb_br_ecc_sed_error_logger.sv
// Directed bench for the SED error logger (DataWidth=8, CountWidth=2, IndexWidth=4).
module tb_br_ecc_sed_error_logger;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dec_valid;
    logic [8:0] dec_codeword;
    logic       dec_error_due;
    logic       clear;
    logic       err_irq;
    logic       err_overflow;
    logic [1:0] err_count;
    logic [8:0] first_err_codeword;
    logic [3:0] first_err_index;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    br_ecc_sed_error_logger #(
        .DataWidth  (8),
        .CountWidth (2),
        .IndexWidth (4)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .dec_valid          (dec_valid),
        .dec_codeword       (dec_codeword),
        .dec_error_due      (dec_error_due),
        .clear              (clear),
        .err_irq            (err_irq),
        .err_overflow       (err_overflow),
        .err_count          (err_count),
        .first_err_codeword (first_err_codeword),
        .first_err_index    (first_err_index)
    );

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [8:0] cw, input logic e, input logic c);
        @(negedge clk);
        dec_valid     = v;
        dec_codeword  = cw;
        dec_error_due = e;
        clear         = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic irq, input logic ovf,
                             input logic [1:0] cnt, input logic [8:0] cw, input logic [3:0] idx);
        check_val({tag, ".irq"}, 16'(err_irq), 16'(irq));
        check_val({tag, ".ovf"}, 16'(err_overflow), 16'(ovf));
        check_val({tag, ".cnt"}, 16'(err_count), 16'(cnt));
        check_val({tag, ".cw"},  16'(first_err_codeword), 16'(cw));
        check_val({tag, ".idx"}, 16'(first_err_index), 16'(idx));
    endtask

    logic [8:0] cw_seq [4] = '{9'h003, 9'h007, 9'h00F, 9'h01F};
    logic       ovf_seq[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    logic [1:0] cnt_seq[4] = '{2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        rst_n = 1'b0; dec_valid = 1'b0; dec_codeword = '0; dec_error_due = 1'b0; clear = 1'b0;
        drive(0, 9'h000, 0, 0);
        drive(0, 9'h000, 0, 0);
        check_all("reset", 0, 0, 2'd0, 9'h000, 4'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            drive(1, 9'h1AB, 0, 0);
            check_all($sformatf("clean%0d", i), 0, 0, 2'd0, 9'h000, 4'd0);
        end

        // Error flag without valid must be ignored.
        drive(0, 9'h123, 1, 0);
        check_all("novalid", 0, 0, 2'd0, 9'h000, 4'd0);

        drive(0, 9'h000, 0, 1);
        for (int i = 0; i < 5; i++) drive(1, 9'h000, 0, 0);
        drive(1, 9'h001, 1, 0);
        check_all("first", 1, 0, 2'd1, 9'h001, 4'd5);

        for (int i = 0; i < 4; i++) begin
            drive(1, cw_seq[i], 1, 0);
            check_all($sformatf("more%0d", i), 1, ovf_seq[i], cnt_seq[i], 9'h001, 4'd5);
        end

        drive(0, 9'h000, 0, 1);
        check_all("clear", 0, 0, 2'd0, 9'h000, 4'd0);
        drive(1, 9'h0AA, 1, 0);
        check_all("after_clr", 1, 0, 2'd1, 9'h0AA, 4'd0);
        drive(1, 9'h055, 1, 0);
        check_all("ovf_again", 1, 1, 2'd2, 9'h0AA, 4'd0);

        drive(1, 9'h0FF, 1, 1);
        check_all("clr_err", 1, 0, 2'd1, 9'h0FF, 4'd0);

        drive(0, 9'h000, 0, 1);
        for (int i = 0; i < 18; i++) drive(1, 9'h000, 0, 0);
        drive(1, 9'h1C3, 1, 0);
        check_all("wrap", 1, 0, 2'd1, 9'h1C3, 4'd2);
        drive(0, 9'h000, 0, 0);
        drive(1, 9'h010, 1, 0);
        check_all("wrap_ovf", 1, 1, 2'd2, 9'h1C3, 4'd2);

        rst_n = 1'b0;
        drive(1, 9'h111, 1, 0);
        check_all("midreset", 0, 0, 2'd0, 9'h000, 4'd0);
        rst_n = 1'b1;
        drive(1, 9'h022, 1, 0);
        check_all("post_rst", 1, 0, 2'd1, 9'h022, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
